div4_seq: RTL and testbench

DIV4_SEQ -- requirements
Module: div4_seq

---
 rtl/div4_pkg.sv | 20 ++
 rtl/rsub.sv | 33 +++
 rtl/div4_seq.sv | 139 +++++++++++++
 tb/tb_div4_seq.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/div4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div4_pkg
// Description : Shared types and constants for the div4_seq restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
package div4_pkg;

  // Default operand / quotient / remainder width
  localparam int unsigned DIV4_WIDTH = 4;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : div4_pkg
`default_nettype wire

// File: rtl/rsub.sv
`default_nettype none
// ============================================================================
// Module      : rsub
// Description : Parameterised ripple subtractor, x - y, built from full-adder
//               cells computing x + ~y + 1. borrow_o is the inverted carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
module rsub #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  output logic [W-1:0] diff_o,
  output logic         borrow_o
);

  logic [W:0] carry;

  // Carry-in of 1 completes the two's complement of y
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_fa
    logic y_n;
    assign y_n          = ~y_i[i];
    assign diff_o[i]    = x_i[i] ^ y_n ^ carry[i];
    assign carry[i + 1] = (x_i[i] & y_n) | (x_i[i] & carry[i]) | (y_n & carry[i]);
  end

  // No carry-out means x < y
  assign borrow_o = ~carry[W];

endmodule : rsub
`default_nettype wire

// File: rtl/div4_seq.sv
`default_nettype none
// ============================================================================
// Module      : div4_seq
// Description : Sequential unsigned restoring divider. One quotient bit per
//               CALC cycle; divide-by-zero short-circuits straight to DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module div4_seq
  import div4_pkg::*;
#(
  parameter int unsigned WIDTH = DIV4_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz
);

  localparam int unsigned      CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] quo_q,   quo_d;
  logic [WIDTH:0]   p_q,     p_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] q_q,     q_d;
  logic [WIDTH-1:0] r_q,     r_d;
  logic             dbz_q,   dbz_d;

  logic [WIDTH:0]   p_sh;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic             unused_p_msb;

  // {P, Q} shifted left by one: P picks up the quotient register's MSB.
  // P's own MSB falls off; after a restoring step it is always 0 anyway.
  assign p_sh         = {p_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign unused_p_msb = p_q[WIDTH];

  rsub #(
    .W (WIDTH + 1)
  ) u_rsub (
    .x_i      (p_sh),
    .y_i      ({1'b0, b_q}),
    .diff_o   (trial),
    .borrow_o (borrow)
  );

  // Next-state and datapath update logic
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    quo_d   = quo_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          b_d   = b;
          p_d   = '0;
          quo_d = a;
          cnt_d = CNT_LOAD;
          if (b == '0) begin
            state_d = DONE;
            q_d     = '1;
            r_d     = a;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        // Restore (keep shifted P) on borrow, otherwise accept the trial
        p_d   = borrow ? p_sh : trial;
        quo_d = {quo_q[WIDTH-2:0], ~borrow};
        if (cnt_q == '0) begin
          state_d = DONE;
          q_d     = {quo_q[WIDTH-2:0], ~borrow};
          r_d     = borrow ? p_sh[WIDTH-1:0] : trial[WIDTH-1:0];
          dbz_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      b_q     <= '0;
      quo_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign q    = q_q;
  assign r    = r_q;
  assign dbz  = dbz_q;

endmodule : div4_seq
`default_nettype wire

// File: tb/tb_div4_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_div4_seq
// Description : Self-checking bench for div4_seq against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div4_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         dbz;

  int n_cmp = 0;
  int n_bad = 0;

  div4_seq #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .dbz   (dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Reference model: plain unsigned division with the divide-by-zero rule
  function automatic int ref_q(int x, int y);
    return (y == 0) ? ((1 << W) - 1) : (x / y);
  endfunction

  function automatic int ref_r(int x, int y);
    return (y == 0) ? x : (x % y);
  endfunction

  // One complete division. Start is driven after edge N and sampled at N+1;
  // done must appear after edge N+W+1 (or N+1 for b == 0), i.e. W (or 0)
  // edges after the sampling edge.
  task automatic do_div(input int ta, input int tb, input bit scramble);
    int lat;
    @(negedge clk);
    start = 1'b1;
    a     = W'(ta);
    b     = W'(tb);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (scramble) begin
      a = W'($urandom);
      b = W'($urandom);
    end
    chk($sformatf("busy %0d/%0d", ta, tb), int'(busy), 1);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk($sformatf("latency %0d/%0d", ta, tb), lat, (tb == 0) ? 0 : W);
    chk($sformatf("q %0d/%0d", ta, tb), int'(q), ref_q(ta, tb));
    chk($sformatf("r %0d/%0d", ta, tb), int'(r), ref_r(ta, tb));
    chk($sformatf("dbz %0d/%0d", ta, tb), int'(dbz), (tb == 0) ? 1 : 0);
    @(posedge clk);
    #1;
    chk($sformatf("done_width %0d/%0d", ta, tb), int'(done), 0);
    chk($sformatf("idle_after %0d/%0d", ta, tb), int'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst q", int'(q), 0);
    chk("rst r", int'(r), 0);
    chk("rst dbz", int'(dbz), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases and boundaries
    do_div(13, 4, 1'b0);
    do_div(15, 1, 1'b1);
    do_div(3, 7, 1'b1);
    do_div(15, 15, 1'b1);
    do_div(9, 0, 1'b1);
    do_div(8, 2, 1'b1);

    // Starts while busy (in CALC and in DONE) must be ignored
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) begin
        start = 1'b1; a = 4'd13; b = 4'd4;
      end else if (c == 2 || c == 5) begin
        start = 1'b1; a = 4'd6; b = 4'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    start = 1'b0;
    chk("ignored pulses", pulses, 1);
    chk("ignored q", int'(q), 3);
    chk("ignored r", int'(r), 1);

    // Reset in the middle of an operation aborts it
    @(negedge clk);
    start = 1'b1; a = 4'd13; b = 4'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst busy", int'(busy), 0);
    chk("midrst done", int'(done), 0);
    chk("midrst q", int'(q), 0);
    chk("midrst r", int'(r), 0);
    chk("midrst dbz", int'(dbz), 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    chk("midrst pulses", pulses, 0);
    do_div(10, 3, 1'b1);

    // Exhaustive sweep, back to back
    for (int ia = 0; ia < (1 << W); ia++) begin
      for (int ib = 0; ib < (1 << W); ib++) begin
        do_div(ia, ib, 1'b1);
      end
    end

    // Random operations with random idle gaps
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      do_div(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_div4_seq
`default_nettype wire
